// File: rtl/pio_db_arbiter.sv
// pio_db_arbiter: round-robin arbiter sharing the PIO doorbell write path among NUM_CH channels.
// Define PIO_DB_COALESCE_EN to let newer doorbells overwrite a still-pending one.
module pio_db_arbiter #(
  parameter int          NUM_CH   = 2,
  parameter int          QID_BASE = 1,
  parameter int          DSTRD    = 0,
  parameter logic [31:0] DB_BASE  = 32'h1000
) (
  input  logic                   axi4_mm_clk,
  input  logic                   axi4_mm_rst,
  input  logic [NUM_CH-1:0]      i_sqdb_valid,
  input  logic [NUM_CH-1:0][63:0] i_sqdb_tail,
  output logic [NUM_CH-1:0]      o_sqdb_ready,
  input  logic [NUM_CH-1:0]      i_cqdb_valid,
  input  logic [NUM_CH-1:0][63:0] i_cqdb_head,
  output logic [NUM_CH-1:0]      o_cqdb_ready,
  output logic                   o_pio_valid,
  output logic [31:0]            o_pio_addr,
  output logic [31:0]            o_pio_data,
  input  logic                   i_pio_ready,
  output logic [31:0]            o_coalesce_cnt
);
  localparam int NR = 2 * NUM_CH;
  localparam int RW = $clog2(NR);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [NR-1:0] pend, ready, req_v, acc, gnt_oh;
  logic [NR-1:0][15:0] val, req_d;
  logic [RW-1:0] rr_ptr, gnt, start, pick;
  logic hs, found, do_grant;
  logic unused_hi;
  int idx;

  // Requester r maps to queue id QID_BASE + r/2; even r is the SQ, odd r the CQ doorbell.
  function automatic logic [31:0] db_addr(input logic [RW-1:0] r);
    return DB_BASE + ((32'(2 * QID_BASE) + 32'(r)) << (2 + DSTRD));
  endfunction

  always_comb begin
    req_v = '0;
    req_d = '0;
    unused_hi = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      req_v[2*c]   = i_sqdb_valid[c];
      req_v[2*c+1] = i_cqdb_valid[c];
      req_d[2*c]   = i_sqdb_tail[c][15:0];
      req_d[2*c+1] = i_cqdb_head[c][15:0];
      unused_hi = unused_hi ^ (^i_sqdb_tail[c][63:16]) ^ (^i_cqdb_head[c][63:16]);
    end
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst)
    if (axi4_mm_rst) state <= IDLE;
    else state <= state_nxt;

  // Cyclic search from rr_ptr, or from the entry after the one just handed off.
  always_comb begin
    hs = (state == SEND) && i_pio_ready;
    start = hs ? ((gnt == RW'(NR - 1)) ? '0 : gnt + 1'b1) : rr_ptr;
    found = 1'b0;
    pick = start;
    idx = 0;
    for (int k = NR - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NR;
      if (pend[idx]) begin
        found = 1'b1;
        pick = RW'(idx);
      end
    end
    do_grant = found && ((state == IDLE) || hs);
    gnt_oh = do_grant ? (NR'(1) << pick) : '0;
    state_nxt = do_grant ? SEND : (hs ? IDLE : state);
  end

  always_comb begin
    o_pio_valid = (state == SEND);
`ifdef PIO_DB_COALESCE_EN
    ready = axi4_mm_rst ? '0 : '1;
`else
    ready = axi4_mm_rst ? '0 : ~pend;
`endif
    acc = req_v & ready;
    o_sqdb_ready = '0;
    o_cqdb_ready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_sqdb_ready[c] = ready[2*c];
      o_cqdb_ready[c] = ready[2*c+1];
    end
  end

  // A granted entry sends its old value; a same-cycle accept refills it and keeps it pending.
  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst)
    if (axi4_mm_rst) begin
      pend <= '0;
      val <= '0;
      rr_ptr <= '0;
      gnt <= '0;
      o_pio_addr <= '0;
      o_pio_data <= '0;
    end else begin
      pend <= (pend & ~gnt_oh) | acc;
      for (int r = 0; r < NR; r++)
        if (acc[r]) val[r] <= req_d[r];
      if (hs) rr_ptr <= start;
      if (do_grant) begin
        gnt <= pick;
        o_pio_addr <= db_addr(pick);
        o_pio_data <= {16'h0, val[pick]};
      end
    end

`ifdef PIO_DB_COALESCE_EN
  logic [NR-1:0] ovw;
  logic [32:0] cnt_sum;
  // Only a pending value that never reaches the output counts as coalesced.
  always_comb begin
    ovw = acc & pend & ~gnt_oh;
    cnt_sum = {1'b0, o_coalesce_cnt} + 33'($countones(ovw));
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst)
    if (axi4_mm_rst) o_coalesce_cnt <= '0;
    else o_coalesce_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
`else
  assign o_coalesce_cnt = '0;
`endif
endmodule
